// File: rtl/writeback_arb.sv
// writeback_arb
//   Collects results from p_num_pipes execute pipes into a single output
//   stage. Each completed entry drives one register-file write (when its
//   wen is set) and one completion toward commit. Pipes are granted
//   round-robin: the search starts at ptr and wraps. ptr moves to the slot
//   after the winner, so every valid pipe is served within p_num_pipes grants.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   X_val / X_rdy                per-pipe valid / accepted-this-cycle
//   X_pc, X_seq_num, X_waddr,
//   X_wdata, X_wen, X_preg,
//   X_ppreg                      per-pipe result fields
//   rf_wen, rf_waddr, rf_wdata   register-file write port
//   C_val / C_rdy                completion handshake toward commit
//   C_pc .. C_ppreg              completion fields, straight from the stage
module writeback_arb #(
  parameter int p_num_pipes      = 3,
  parameter int p_seq_num_bits   = 5,
  parameter int p_phys_addr_bits = 6
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic [p_num_pipes-1:0]                           X_val,
  output logic [p_num_pipes-1:0]                           X_rdy,
  input  logic [p_num_pipes-1:0][31:0]                     X_pc,
  input  logic [p_num_pipes-1:0][p_seq_num_bits-1:0]       X_seq_num,
  input  logic [p_num_pipes-1:0][4:0]                      X_waddr,
  input  logic [p_num_pipes-1:0][31:0]                     X_wdata,
  input  logic [p_num_pipes-1:0]                           X_wen,
  input  logic [p_num_pipes-1:0][p_phys_addr_bits-1:0]     X_preg,
  input  logic [p_num_pipes-1:0][p_phys_addr_bits-1:0]     X_ppreg,
  output logic                                             rf_wen,
  output logic [p_phys_addr_bits-1:0]                      rf_waddr,
  output logic [31:0]                                      rf_wdata,
  output logic                                             C_val,
  input  logic                                             C_rdy,
  output logic [31:0]                                      C_pc,
  output logic [p_seq_num_bits-1:0]                        C_seq_num,
  output logic [4:0]                                       C_waddr,
  output logic [31:0]                                      C_wdata,
  output logic                                             C_wen,
  output logic [p_phys_addr_bits-1:0]                      C_preg,
  output logic [p_phys_addr_bits-1:0]                      C_ppreg
);

  localparam int PTR_BITS = (p_num_pipes > 1) ? $clog2(p_num_pipes) : 1;

  logic [PTR_BITS-1:0]         ptr_q, ptr_d;
  logic [PTR_BITS-1:0]         grant_idx;
  logic                        grant_found;
  logic                        out_val_q, out_val_d;
  logic                        stage_free;
  logic                        x_xfer;
  logic                        c_xfer;

  logic [31:0]                 pc_q;
  logic [p_seq_num_bits-1:0]   seq_num_q;
  logic [4:0]                  waddr_q;
  logic [31:0]                 wdata_q;
  logic                        wen_q;
  logic [p_phys_addr_bits-1:0] preg_q;
  logic [p_phys_addr_bits-1:0] ppreg_q;

  // Round-robin search starting at ptr. Only X_val and ptr feed the grant,
  // so X_rdy never depends on the data fields.
  always_comb begin : grant_search
    int                  idx;
    logic [PTR_BITS-1:0] cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    cand        = '0;
    for (int k = 0; k < p_num_pipes; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= p_num_pipes) begin
        idx = idx - p_num_pipes;
      end
      cand = PTR_BITS'(idx);
      if (!grant_found && X_val[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // The stage can take a new entry when empty or when it is draining this
  // cycle. Reset blocks both handshakes so nothing moves while rst is high.
  assign stage_free = !out_val_q || C_rdy;
  assign x_xfer     = grant_found && stage_free && !rst;
  assign c_xfer     = out_val_q && C_rdy && !rst;

  always_comb begin : rdy_decode
    X_rdy = '0;
    if (x_xfer) begin
      X_rdy[grant_idx] = 1'b1;
    end
  end

  always_comb begin : next_state
    out_val_d = out_val_q;
    ptr_d     = ptr_q;
    if (x_xfer) begin
      // A load wins over a drain: back-to-back results keep out_val high.
      out_val_d = 1'b1;
      ptr_d     = (grant_idx == PTR_BITS'(p_num_pipes - 1)) ? '0
                                                            : grant_idx + PTR_BITS'(1);
    end else if (c_xfer) begin
      out_val_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_val_q <= 1'b0;
      ptr_q     <= '0;
    end else begin
      out_val_q <= out_val_d;
      ptr_q     <= ptr_d;
    end
  end

  // Payload needs no reset: it is only observed while out_val_q is set.
  always_ff @(posedge clk) begin
    if (x_xfer) begin
      pc_q      <= X_pc[grant_idx];
      seq_num_q <= X_seq_num[grant_idx];
      waddr_q   <= X_waddr[grant_idx];
      wdata_q   <= X_wdata[grant_idx];
      wen_q     <= X_wen[grant_idx];
      preg_q    <= X_preg[grant_idx];
      ppreg_q   <= X_ppreg[grant_idx];
    end
  end

  // The register file is written on the completion handshake itself, so each
  // entry is written exactly once, and never for an entry discarded by reset.
  assign C_val     = out_val_q && !rst;
  assign rf_wen    = c_xfer && wen_q;
  assign rf_waddr  = preg_q;
  assign rf_wdata  = wdata_q;

  assign C_pc      = pc_q;
  assign C_seq_num = seq_num_q;
  assign C_waddr   = waddr_q;
  assign C_wdata   = wdata_q;
  assign C_wen     = wen_q;
  assign C_preg    = preg_q;
  assign C_ppreg   = ppreg_q;

endmodule

// File: tb/tb_writeback_arb.sv
// tb_writeback_arb
//   Directed scenarios plus a randomized run checked against a small
//   behavioural model of the writeback stage (round-robin grant, one-entry
//   output stage, register-file write on completion).
module tb_writeback_arb;
  localparam int N  = 3;
  localparam int SW = 5;
  localparam int PW = 6;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N-1:0]           X_val, X_rdy, X_wen;
  logic [N-1:0][31:0]     X_pc, X_wdata;
  logic [N-1:0][SW-1:0]   X_seq_num;
  logic [N-1:0][4:0]      X_waddr;
  logic [N-1:0][PW-1:0]   X_preg, X_ppreg;
  logic                   rf_wen;
  logic [PW-1:0]          rf_waddr;
  logic [31:0]            rf_wdata;
  logic                   C_val, C_rdy;
  logic [31:0]            C_pc, C_wdata;
  logic [SW-1:0]          C_seq_num;
  logic [4:0]             C_waddr;
  logic                   C_wen;
  logic [PW-1:0]          C_preg, C_ppreg;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  logic          m_val = 1'b0;
  int            m_ptr = 0;
  logic [31:0]   m_pc, m_wdata;
  logic [SW-1:0] m_seq;
  logic [4:0]    m_waddr;
  logic          m_wen;
  logic [PW-1:0] m_preg, m_ppreg;
  logic          m_found;
  int            m_g;
  logic [N-1:0]  exp_rdy;
  logic          exp_cval, exp_rfwen;

  always #5 clk = ~clk;

  writeback_arb #(.p_num_pipes(N), .p_seq_num_bits(SW), .p_phys_addr_bits(PW)) dut (
    .clk(clk), .rst(rst),
    .X_val(X_val), .X_rdy(X_rdy), .X_pc(X_pc), .X_seq_num(X_seq_num),
    .X_waddr(X_waddr), .X_wdata(X_wdata), .X_wen(X_wen),
    .X_preg(X_preg), .X_ppreg(X_ppreg),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .C_val(C_val), .C_rdy(C_rdy), .C_pc(C_pc), .C_seq_num(C_seq_num),
    .C_waddr(C_waddr), .C_wdata(C_wdata), .C_wen(C_wen),
    .C_preg(C_preg), .C_ppreg(C_ppreg)
  );

  // Expected outputs for the current inputs and model state.
  task automatic model_expect();
    int p;
    m_found = 1'b0;
    m_g     = 0;
    for (int k = 0; k < N; k++) begin
      p = (m_ptr + k) % N;
      if (!m_found && X_val[p]) begin
        m_found = 1'b1;
        m_g     = p;
      end
    end
    exp_rdy = '0;
    if (!rst && m_found && (!m_val || C_rdy)) exp_rdy = N'(1) << m_g;
    exp_cval  = m_val && !rst;
    exp_rfwen = exp_cval && C_rdy && m_wen;
  endtask

  // Advance the model across one rising edge.
  task automatic model_clock();
    model_expect();
    if (rst) begin
      m_val = 1'b0;
      m_ptr = 0;
    end else if (exp_rdy != '0) begin
      m_val   = 1'b1;
      m_pc    = X_pc[m_g];
      m_seq   = X_seq_num[m_g];
      m_waddr = X_waddr[m_g];
      m_wdata = X_wdata[m_g];
      m_wen   = X_wen[m_g];
      m_preg  = X_preg[m_g];
      m_ppreg = X_ppreg[m_g];
      m_ptr   = (m_g + 1) % N;
    end else if (m_val && C_rdy) begin
      m_val = 1'b0;
    end
  endtask

  task automatic tick();
    model_clock();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst   = 1'b1;
    X_val = '0;
    C_rdy = 1'b0;
    #1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    C_rdy = 1'b1;
    X_val = '1;
    tick();
    tick();
    #1;
    checks++; if (C_val !== 1'b0) $display("FAIL reset_cval: got %b expected 0", C_val);
    if (C_val !== 1'b0) errors++;
    checks++; if (rf_wen !== 1'b0) begin $display("FAIL reset_rfwen: got %b expected 0", rf_wen); errors++; end
    checks++; if (X_rdy !== 3'b000) begin $display("FAIL reset_xrdy: got %b expected 000", X_rdy); errors++; end
    tick();
    rst   = 1'b0;
    X_val = '0;
  endtask

  task automatic test_single();
    apply_reset();
    X_val = 3'b010; X_seq_num[1] = 5'd3; X_preg[1] = 6'h0A;
    X_wdata[1] = 32'h1234; X_wen[1] = 1'b1; C_rdy = 1'b1;
    #1;
    checks++; if (X_rdy !== 3'b010) begin $display("FAIL single_xrdy: got %b expected 010", X_rdy); errors++; end
    tick();
    X_val = '0;
    #1;
    checks++; if (C_val !== 1'b1) begin $display("FAIL single_cval: got %b expected 1", C_val); errors++; end
    checks++; if (C_seq_num !== 5'd3) begin $display("FAIL single_seq: got %0d expected 3", C_seq_num); errors++; end
    checks++; if (rf_wen !== 1'b1) begin $display("FAIL single_rfwen: got %b expected 1", rf_wen); errors++; end
    checks++; if (rf_waddr !== 6'h0A) begin $display("FAIL single_rfwaddr: got %h expected 0a", rf_waddr); errors++; end
    checks++; if (rf_wdata !== 32'h1234) begin $display("FAIL single_rfwdata: got %h expected 1234", rf_wdata); errors++; end
    $display("txn single: pipe=1 seq=%0d rf_waddr=%h rf_wdata=%h", C_seq_num, rf_waddr, rf_wdata);
    tick();
  endtask

  task automatic test_fairness();
    logic [N-1:0] e;
    apply_reset();
    C_rdy = 1'b1;
    for (int i = 0; i <= 6; i++) begin
      X_val = '1;
      for (int p = 0; p < N; p++) X_seq_num[p] = SW'(i * 4 + p);
      #1;
      if (i > 0) begin
        checks++;
        if (C_val !== 1'b1 || C_seq_num !== SW'((i - 1) * 4 + (i - 1) % 3)) begin
          $display("FAIL fair_cmpl%0d: got val=%b seq=%0d expected val=1 seq=%0d",
                   i, C_val, C_seq_num, (i - 1) * 4 + (i - 1) % 3);
          errors++;
        end
      end
      if (i < 6) begin
        e = 3'b001 << (i % 3);
        checks++;
        if (X_rdy !== e) begin $display("FAIL fair_grant%0d: got %b expected %b", i, X_rdy, e); errors++; end
        $display("txn fair: cycle=%0d grant=%b", i, X_rdy);
      end
      tick();
    end
    X_val = '0;
    tick();
  endtask

  task automatic test_backpressure();
    apply_reset();
    X_val = 3'b001; X_seq_num[0] = 5'd1; X_wen[0] = 1'b1;
    X_preg[0] = 6'h05; X_wdata[0] = 32'hAA; C_rdy = 1'b1;
    #1;
    tick();
    C_rdy = 1'b0; X_seq_num[0] = 5'd2; X_wdata[0] = 32'hBB;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (X_rdy !== 3'b000 || C_val !== 1'b1 || C_seq_num !== 5'd1 ||
          C_wdata !== 32'hAA || rf_wen !== 1'b0) begin
        $display("FAIL bp_hold%0d: got rdy=%b val=%b seq=%0d wdata=%h rfwen=%b expected rdy=000 val=1 seq=1 wdata=aa rfwen=0",
                 i, X_rdy, C_val, C_seq_num, C_wdata, rf_wen);
        errors++;
      end
      tick();
    end
    C_rdy = 1'b1;
    #1;
    checks++;
    if (rf_wen !== 1'b1 || rf_wdata !== 32'hAA || X_rdy !== 3'b001) begin
      $display("FAIL bp_release: got rfwen=%b rfwdata=%h rdy=%b expected rfwen=1 rfwdata=aa rdy=001",
               rf_wen, rf_wdata, X_rdy);
      errors++;
    end
    tick();
    X_val = '0;
    #1;
    checks++;
    if (C_val !== 1'b1 || C_seq_num !== 5'd2 || C_wdata !== 32'hBB) begin
      $display("FAIL bp_next: got val=%b seq=%0d wdata=%h expected val=1 seq=2 wdata=bb", C_val, C_seq_num, C_wdata);
      errors++;
    end
    $display("txn backpressure: seq=%0d wdata=%h", C_seq_num, C_wdata);
    tick();
  endtask

  task automatic test_wrap();
    apply_reset();
    C_rdy = 1'b1;
    X_val = 3'b010;
    #1;
    tick();
    X_val = 3'b011;
    #1;
    checks++; if (X_rdy !== 3'b001) begin $display("FAIL wrap_grant: got %b expected 001", X_rdy); errors++; end
    tick();
    #1;
    checks++; if (X_rdy !== 3'b010) begin $display("FAIL wrap_ptr: got %b expected 010", X_rdy); errors++; end
    $display("txn wrap: grant=%b", X_rdy);
    tick();
    X_val = '0;
    tick();
  endtask

  task automatic test_wen0();
    apply_reset();
    C_rdy = 1'b1;
    X_val = 3'b100; X_seq_num[2] = 5'd7; X_wen[2] = 1'b0; X_preg[2] = 6'h3F;
    #1;
    checks++; if (X_rdy !== 3'b100) begin $display("FAIL wen0_xrdy: got %b expected 100", X_rdy); errors++; end
    tick();
    X_val = '0;
    #1;
    checks++;
    if (C_val !== 1'b1 || C_seq_num !== 5'd7 || rf_wen !== 1'b0) begin
      $display("FAIL wen0_cmpl: got val=%b seq=%0d rfwen=%b expected val=1 seq=7 rfwen=0", C_val, C_seq_num, rf_wen);
      errors++;
    end
    $display("txn wen0: seq=%0d rf_wen=%b", C_seq_num, rf_wen);
    tick();
    #1;
    checks++; if (C_val !== 1'b0) begin $display("FAIL wen0_drain: got %b expected 0", C_val); errors++; end
  endtask

  task automatic test_reset_midop();
    apply_reset();
    C_rdy = 1'b1;
    X_val = 3'b001; X_wen[0] = 1'b1;
    #1;
    tick();
    C_rdy = 1'b0; X_val = '0;
    #1;
    checks++; if (C_val !== 1'b1) begin $display("FAIL midop_full: got %b expected 1", C_val); errors++; end
    rst = 1'b1; X_val = '1;
    #1;
    checks++;
    if (C_val !== 1'b0 || rf_wen !== 1'b0 || X_rdy !== 3'b000) begin
      $display("FAIL midop_inrst: got val=%b rfwen=%b rdy=%b expected 0 0 000", C_val, rf_wen, X_rdy);
      errors++;
    end
    tick();
    rst = 1'b0; X_val = '0; C_rdy = 1'b1;
    #1;
    checks++;
    if (C_val !== 1'b0 || rf_wen !== 1'b0) begin
      $display("FAIL midop_after: got val=%b rfwen=%b expected 0 0", C_val, rf_wen);
      errors++;
    end
    X_val = 3'b111;
    #1;
    checks++; if (X_rdy !== 3'b001) begin $display("FAIL midop_grant: got %b expected 001", X_rdy); errors++; end
    $display("txn reset_midop: first grant=%b", X_rdy);
    tick();
    X_val = '0;
    tick();
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      rst   = ($urandom_range(0, 49) == 0);
      C_rdy = ($urandom_range(0, 3) != 0);
      for (int p = 0; p < N; p++) begin
        X_val[p]     = 1'($urandom_range(0, 1));
        X_pc[p]      = $urandom;
        X_seq_num[p] = SW'($urandom);
        X_waddr[p]   = 5'($urandom);
        X_wdata[p]   = $urandom;
        X_wen[p]     = 1'($urandom_range(0, 1));
        X_preg[p]    = PW'($urandom);
        X_ppreg[p]   = PW'($urandom);
      end
      #1;
      model_expect();
      checks++; if (X_rdy !== exp_rdy) begin $display("FAIL rand_xrdy c=%0d: got %b expected %b", c, X_rdy, exp_rdy); errors++; end
      checks++; if (C_val !== exp_cval) begin $display("FAIL rand_cval c=%0d: got %b expected %b", c, C_val, exp_cval); errors++; end
      checks++; if (rf_wen !== exp_rfwen) begin $display("FAIL rand_rfwen c=%0d: got %b expected %b", c, rf_wen, exp_rfwen); errors++; end
      if (exp_cval) begin
        checks++;
        if ({C_pc, C_seq_num, C_waddr, C_wdata, C_wen, C_preg, C_ppreg} !==
            {m_pc, m_seq, m_waddr, m_wdata, m_wen, m_preg, m_ppreg}) begin
          $display("FAIL rand_fields c=%0d: got pc=%h seq=%0d wd=%h preg=%h expected pc=%h seq=%0d wd=%h preg=%h",
                   c, C_pc, C_seq_num, C_wdata, C_preg, m_pc, m_seq, m_wdata, m_preg);
          errors++;
        end
        if (C_rdy) $display("txn rand: c=%0d pc=%h seq=%0d wen=%b", c, C_pc, C_seq_num, C_wen);
      end
      if (exp_rfwen) begin
        checks++;
        if (rf_waddr !== m_preg || rf_wdata !== m_wdata) begin
          $display("FAIL rand_rfport c=%0d: got %h/%h expected %h/%h", c, rf_waddr, rf_wdata, m_preg, m_wdata);
          errors++;
        end
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; C_rdy = 1'b0; X_val = '0; X_wen = '0;
    X_pc = '0; X_wdata = '0; X_seq_num = '0; X_waddr = '0; X_preg = '0; X_ppreg = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_wrap();
    test_wen0();
    test_reset_midop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/writeback_arb.md
WRITEBACK_ARB -- requirements
Module: writeback_arb

Interface
REQ-001 Parameter p_num_pipes, default 3: number of execute pipes feeding writeback, range 2..8.
REQ-002 Parameter p_seq_num_bits, default 5: sequence-number width.
REQ-003 Parameter p_phys_addr_bits, default 6: physical-register index width.
REQ-004 clk  input  1  clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 X_val  input  [p_num_pipes]  per-pipe result valid.
REQ-007 X_rdy  output  [p_num_pipes]  per-pipe result accepted this cycle.
REQ-008 X_pc  input  [p_num_pipes][32]  per-pipe instruction PC.
REQ-009 X_seq_num  input  [p_num_pipes][p_seq_num_bits]  per-pipe sequence number.
REQ-010 X_waddr  input  [p_num_pipes][5]  per-pipe architectural destination.
REQ-011 X_wdata  input  [p_num_pipes][32]  per-pipe result data.
REQ-012 X_wen  input  [p_num_pipes]  per-pipe register-write enable.
REQ-013 X_preg, X_ppreg  input  [p_num_pipes][p_phys_addr_bits]  per-pipe new and previous physical register.
REQ-014 rf_wen  output  1  register-file write strobe.
REQ-015 rf_waddr  output  p_phys_addr_bits  register-file write index.
REQ-016 rf_wdata  output  32  register-file write data.
REQ-017 C_val  output  1  completion valid to commit.
REQ-018 C_rdy  input  1  commit ready.
REQ-019 C_pc, C_seq_num, C_waddr, C_wdata, C_wen, C_preg, C_ppreg  output  widths as X_*  completion fields.

Function
REQ-020 Block SHALL hold one output stage: out_val plus one copy of all X fields.
REQ-021 Stage SHALL be free when !out_val or C_rdy is high (C_val & C_rdy transfer).
REQ-022 Grant SHALL select the first pipe i with X_val[i], searching from index ptr upward, wrapping from p_num_pipes-1 to 0; no grant when no X_val.
REQ-023 X_rdy[i] SHALL be high only for the granted pipe and only when the stage is free; at most one X_rdy bit high per cycle.
REQ-024 X_rdy SHALL depend combinationally on X_val, ptr, out_val, C_rdy only, never on X data fields.
REQ-025 On an X transfer from pipe g the stage SHALL load pipe g fields and set out_val=1 next cycle (latency 1 cycle X transfer -> C_val).
REQ-026 On an X transfer from pipe g, ptr SHALL become (g+1) mod p_num_pipes; ptr SHALL hold otherwise.
REQ-027 On C transfer without X transfer, out_val SHALL clear next cycle; simultaneous C and X transfer SHALL load new entry with out_val staying 1 (full throughput, one result per cycle).
REQ-028 With C_rdy low and out_val high, stage contents and C_* outputs SHALL hold stable and all X_rdy SHALL be low.
REQ-029 C_val SHALL equal out_val; C_* fields SHALL be driven directly from the stage.
REQ-030 rf_wen SHALL equal out_val & C_rdy & C_wen; rf_waddr=C_preg; rf_wdata=C_wdata; register file written exactly once per completed instruction.
REQ-031 Entries with wen=0 SHALL still be completed to commit, with rf_wen low.
REQ-032 Block SHALL not reorder results from a single pipe; no cross-pipe ordering guarantee.

Reset
REQ-033 While rst high: out_val=0, C_val=0, rf_wen=0, ptr=0, all X_rdy=0.
REQ-034 rst asserted with an entry in the stage SHALL discard it with no rf write; first post-reset grant SHALL start search at pipe 0.

Verification
REQ-035 Single: pipe1 X_val, seq 3, preg 0x0A, wdata 0x1234, wen 1, C_rdy=1 -> X_rdy[1] same cycle; next cycle C_val=1, C_seq_num=3, rf_wen=1, rf_waddr=0x0A, rf_wdata=0x1234.
REQ-036 Fairness: all 3 pipes valid continuously, C_rdy=1 -> grants 0,1,2,0,1,2, one completion per cycle.
REQ-037 Backpressure: stage full, C_rdy=0 for 4 cycles, pipe0 valid -> X_rdy all 0, C_* stable, rf_wen 0; C_rdy=1 -> completion, pipe0 accepted same cycle.
REQ-038 Wrap: ptr=2, only pipe0 and pipe1 valid -> pipe0 granted, ptr becomes 1.
REQ-039 wen=0: pipe2 wen 0, seq 7 -> C_val with C_seq_num=7, rf_wen stays 0.
REQ-040 Reset mid-op: stage full, C_rdy=0, rst 1 cycle -> C_val=0, no rf write, next grant searches from pipe 0.
